u32_to_fp_sp_arbiter: RTL and testbench
=======================================

# u32_to_fp_sp_arbiter

Shares one U32-to-float (FloPoCo single precision) converter between `NUM_REQ` requesters. A round-robin arbiter issues at most one operand per enabled cycle. A tag pipeline matched to the converter latency routes each 34-bit FloPoCo result back to its originator. The block sits between the integer-producing units and a single converter instance, which the block drives through `conv_I`/`conv_O`. That converter is instantiated alongside with the same `NUM_STAGES` and the same `clk`/`ce`.

## Interface
- `NUM_REQ`, 4: number of requesters; legal 2..16.
- `NUM_STAGES`, 1: pipeline depth of the attached converter; legal 0, 1, 5.
- `ID_W`, localparam: `$clog2(NUM_REQ)`.

- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  clock enable. When `ce` is low, all state holds and no handshake completes.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_data`  in  NUM_REQ*32  operands; requester k occupies bits [32k+31:32k].
- `req_ready`  out  NUM_REQ  one-hot grant; at most one bit is high.
- `conv_I`  out  32  operand to the converter (registered).
- `conv_O`  in  34  converter result.
- `resp_valid`  out  NUM_REQ  one-hot result strobe; at most one bit is high.
- `resp_data`  out  34  result, valid while any `resp_valid` bit is high.
- `busy`  out  1  high while any accepted operand has not yet produced its result.

## Operation
- **Acceptance.** Requester k is accepted when `req_valid[k] & req_ready[k]`.
- **Ready generation.** `req_ready` is combinational from `req_valid`, the priority pointer and `ce`. It is all-zero when `ce=0` or `rst=1`. Requesters hold `req_valid` and `req_data` until accepted. There is no backpressure from the result side, so a grant is never withheld for output reasons.
- **Arbitration.**
  - Priority starts at `ptr+1` and wraps modulo `NUM_REQ`.
  - `ptr` is loaded with the granted index on acceptance and is unchanged otherwise.
  - Reset value of `ptr` is `NUM_REQ-1`, so requester 0 has top priority first.
- **Issue stage.**
  - On acceptance, `issue_valid<=1`, `conv_I<=req_data[k]`, `issue_id<=k`.
  - On an enabled cycle with no acceptance, `issue_valid<=0` and `conv_I` holds its value.
- **Tag pipeline.** A shift register `NUM_STAGES` deep, with entries of {valid, id}. It is fed from `issue_valid`/`issue_id` and advances only when `ce=1`. It models the converter's fixed latency exactly.
- **Response.**
  - `resp_valid[id]=1` for the tag leaving the pipe.
  - `resp_data=conv_O` is passed through combinationally.
  - For `NUM_STAGES=0` the tag pipe is empty, and response is taken directly from the issue stage.
  - `resp_valid` is all-zero when `ce=0`, so a strobe counts exactly once.
- **busy.** The OR of `issue_valid` and all tag-pipe valid bits.
- **Reset.** Synchronous reset clears the following:
  - `issue_valid` and every tag valid.
  - `ptr` (to `NUM_REQ-1`).
  - `conv_I` (to 0).
  - `resp_valid`, `req_ready` and `busy` (to 0).
  - `resp_data` follows `conv_O`; its value is don't-care while `resp_valid` is 0.

  Operands in flight at reset are discarded and produce no response. The external converter is not reset; its stale outputs are masked by the cleared tags.

## Timing
- **Latency.** An operand accepted in enabled cycle t appears on `conv_I` in cycle t+1. Its response strobes in enabled cycle t+1+`NUM_STAGES`:
  - 1 cycle for `NUM_STAGES=0`.
  - 2 cycles for `NUM_STAGES=1`.
  - 6 cycles for `NUM_STAGES=5`.

  Latency is counted in `ce=1` cycles; cycles with `ce=0` stretch it without loss or duplication.
- **Throughput.** One operand per enabled cycle in aggregate. Responses return in acceptance order.
- **Simultaneous requests.** All valid requests are served within `NUM_REQ` consecutive enabled cycles (no starvation, round-robin build).
- **Coincident accept and return.** Accepting a new operand in the same cycle that a response returns is legal and fully pipelined.
- **Reset priority.** `rst` has priority over `ce`. Reset is applied even when `ce=0`.

## Configuration
- **`U32_FP_ARB_RR_EN`.**
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority, where the lowest asserted index always wins. `ptr` is removed, and starvation of higher indices is permitted.
- Latency, ordering and reset behaviour are identical in both builds.

## Test plan
- **Single request, all depths.** With `NUM_STAGES=1`, requester 2 sends 0x00000001 with `ce=1`. Required: `conv_I=0x00000001` the next cycle, then `resp_valid=4'b0100` two cycles after acceptance, with `resp_data` equal to the converter's encoding of 1.0. Repeat with `NUM_STAGES=0` (expect 1 cycle) and `NUM_STAGES=5` (expect 6 cycles).
- **Round-robin fairness.** `NUM_REQ=4`, `U32_FP_ARB_RR_EN` defined, all `req_valid` held high. Required grant order after reset: 0,1,2,3,0,… with exactly one grant per cycle. Responses follow in the same order with no gaps.
- **Fixed-priority build.** Macro undefined, requesters 1 and 3 held valid. Required: requester 1 is granted every cycle and requester 3 is never granted.
- **Clock-enable stall.** `NUM_STAGES=5`, 3 back-to-back operands, then `ce` deasserted for 4 cycles mid-flight. Required: no `req_ready` or `resp_valid` during the stall. After the stall, all 3 responses arrive with correct ids, exactly once each, 6 enabled cycles after their respective acceptances.
- **Reset mid-operation.** `rst` pulsed 1 cycle while 2 operands are in flight, with `ce=0` during the reset cycle. Required: the cleared-state list from Reset (`conv_I=0`, all other outputs 0) holds on the next cycle. Neither in-flight operand ever produces `resp_valid`. The first grant after reset goes to the lowest-index valid requester.

Source files
------------

// File: rtl/u32_to_fp_sp_arbiter.sv
// Shares one U32-to-FloPoCo-float converter between NUM_REQ requesters with a tag pipe matched to its latency.
// Build option: define U32_FP_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module u32_to_fp_sp_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_STAGES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            conv_I,
  input  logic [33:0]            conv_O,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [33:0]            resp_data,
  output logic                   busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TP_D = (NUM_STAGES > 0) ? NUM_STAGES : 1;

  logic            accept;
  logic [ID_W-1:0] grant_id;

  // Grant stage: combinational, one-hot, suppressed by reset and by a stalled clock enable.
`ifdef U32_FP_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
  int unsigned     idx;

  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (!rst && ce) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        idx = (int'(ptr_q) + i) % NUM_REQ;
        if (!accept && req_valid[idx]) begin
          accept         = 1'b1;
          grant_id       = ID_W'(idx);
          req_ready[idx] = 1'b1;
        end
      end
    end
    ptr_d = accept ? grant_id : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
    end else if (ce) begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    grant_id  = '0;
    if (!rst && ce) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!accept && req_valid[i]) begin
          accept       = 1'b1;
          grant_id     = ID_W'(i);
          req_ready[i] = 1'b1;
        end
      end
    end
  end
`endif

  // Issue stage: operand register feeding the converter, plus the tag that travels with it.
  logic            issue_vld_q, issue_vld_d;
  logic [ID_W-1:0] issue_id_q, issue_id_d;
  logic [31:0]     conv_i_q, conv_i_d;

  always_comb begin
    issue_vld_d = accept;
    issue_id_d  = accept ? grant_id : issue_id_q;
    conv_i_d    = accept ? req_data[32*int'(grant_id) +: 32] : conv_i_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_vld_q <= 1'b0;
      conv_i_q    <= '0;
    end else if (ce) begin
      issue_vld_q <= issue_vld_d;
      conv_i_q    <= conv_i_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      issue_id_q <= issue_id_d;
    end
  end

  assign conv_I = conv_i_q;

  // Tag pipe stage: mirrors the converter depth so the tag leaving it matches conv_O.
  logic            out_vld;
  logic [ID_W-1:0] out_id;

  generate
    if (NUM_STAGES > 0) begin : g_pipe
      logic [TP_D-1:0] tag_vld_q, tag_vld_d;
      logic [ID_W-1:0] tag_id_q [TP_D];
      logic [ID_W-1:0] tag_id_d [TP_D];

      always_comb begin
        tag_vld_d[0] = issue_vld_q;
        tag_id_d[0]  = issue_id_q;
        for (int j = 1; j < TP_D; j++) begin
          tag_vld_d[j] = tag_vld_q[j-1];
          tag_id_d[j]  = tag_id_q[j-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          tag_vld_q <= '0;
        end else if (ce) begin
          tag_vld_q <= tag_vld_d;
        end
      end

      always_ff @(posedge clk) begin
        if (ce) begin
          tag_id_q <= tag_id_d;
        end
      end

      always_comb begin
        out_vld = tag_vld_q[TP_D-1];
        out_id  = tag_id_q[TP_D-1];
        busy    = issue_vld_q | (|tag_vld_q);
      end
    end else begin : g_nopipe
      always_comb begin
        out_vld = issue_vld_q;
        out_id  = issue_id_q;
        busy    = issue_vld_q;
      end
    end
  endgenerate

  // Response stage: strobe only on enabled cycles so each result is counted once.
  always_comb begin
    resp_valid = '0;
    if (!rst && ce && out_vld) begin
      resp_valid[out_id] = 1'b1;
    end
  end

  assign resp_data = conv_O;

endmodule

// File: tb/tb_u32_to_fp_sp_arbiter.sv
// Bench: three arbiters (converter depths 0, 1, 5) share one stimulus; a queue model checks every cycle.
module tb_u32_to_fp_sp_arbiter;
  localparam int NUM_REQ = 4;

  logic                  clk;
  logic                  rst;
  logic                  ce;
  logic [NUM_REQ-1:0]    vld;
  logic [31:0]           dat [NUM_REQ];
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_data;

  logic [NUM_REQ-1:0] rdy_a [3];
  logic [NUM_REQ-1:0] rv_a  [3];
  logic [31:0]        ci_a  [3];
  logic [33:0]        rd_a  [3];
  logic [33:0]        co_a  [3];
  logic               busy_a[3];

  int n_chk;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign req_valid = vld;
  always_comb begin
    req_data = '0;
    for (int k = 0; k < NUM_REQ; k++) req_data[32*k +: 32] = dat[k];
  end

  function automatic int depth(input int s);
    return (s == 0) ? 0 : (s == 1) ? 1 : 5;
  endfunction

  // Reference U32 -> FloPoCo single: {exn(2), sign, exp(8), frac(23)}, round to nearest even.
  function automatic logic [33:0] cvt(input logic [31:0] x);
    longint unsigned v, mant, rem, half;
    int m, sh;
    if (x == 32'd0) return 34'h0;
    v = {32'd0, x};
    m = 31;
    while (!x[m]) m--;
    if (m <= 23) begin
      mant = v << (23 - m);
    end else begin
      sh   = m - 23;
      mant = v >> sh;
      rem  = v & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
      if (mant == (64'd1 << 24)) begin
        mant = mant >> 1;
        m    = m + 1;
      end
    end
    return {2'b01, 1'b0, 8'(127 + m), mant[22:0]};
  endfunction

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 0 : (g == 1) ? 1 : 5;
    logic [33:0] cp [6];
    always @(posedge clk) begin
      if (ce) begin
        cp[0] <= cvt(ci_a[g]);
        for (int j = 1; j < 6; j++) cp[j] <= cp[j-1];
      end
    end
    assign co_a[g] = (S == 0) ? cvt(ci_a[g]) : cp[(S == 0) ? 0 : S - 1];

    u32_to_fp_sp_arbiter #(.NUM_REQ(NUM_REQ), .NUM_STAGES(S)) dut (
      .clk(clk), .rst(rst), .ce(ce),
      .req_valid(req_valid), .req_data(req_data), .req_ready(rdy_a[g]),
      .conv_I(ci_a[g]), .conv_O(co_a[g]),
      .resp_valid(rv_a[g]), .resp_data(rd_a[g]), .busy(busy_a[g]));
  end

  typedef struct {
    int          id;
    logic [31:0] d;
    longint      acc;
  } ent_t;

  ent_t               hist[$];
  ent_t               ent;
  int                 head [3];
  longint             ecnt;
  logic [31:0]        mconv;
  logic [NUM_REQ-1:0] m_rdy;
  logic [NUM_REQ-1:0] m_rv;
  int                 gid;
`ifdef U32_FP_ARB_RR_EN
  int                 mptr;
`endif

  initial begin
    head  = '{0, 0, 0};
    ecnt  = 0;
    mconv = '0;
`ifdef U32_FP_ARB_RR_EN
    mptr  = NUM_REQ - 1;
`endif
  end

  // Model: accepted operands are queued with the enabled-cycle index of acceptance;
  // depth-S instance must return each one at enabled cycle acc+1+S, in order.
  always @(negedge clk) begin
    m_rdy = '0;
    gid   = -1;
    if (!rst && ce) begin
`ifdef U32_FP_ARB_RR_EN
      for (int i = 1; i <= NUM_REQ; i++)
        if (gid < 0 && req_valid[(mptr + i) % NUM_REQ]) gid = (mptr + i) % NUM_REQ;
`else
      for (int i = 0; i < NUM_REQ; i++)
        if (gid < 0 && req_valid[i]) gid = i;
`endif
      if (gid >= 0) m_rdy[gid] = 1'b1;
    end
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("req_ready[S=%0d]", depth(s)), 64'(rdy_a[s]), 64'(m_rdy));
      chk($sformatf("conv_I[S=%0d]", depth(s)), 64'(ci_a[s]), 64'(mconv));
      chk($sformatf("busy[S=%0d]", depth(s)), 64'(busy_a[s]), 64'(hist.size() > head[s]));
      m_rv = '0;
      if (!rst && ce && hist.size() > head[s] && hist[head[s]].acc + 1 + depth(s) == ecnt) begin
        m_rv[hist[head[s]].id] = 1'b1;
        chk($sformatf("resp_valid[S=%0d]", depth(s)), 64'(rv_a[s]), 64'(m_rv));
        chk($sformatf("resp_data[S=%0d]", depth(s)), 64'(rd_a[s]), 64'(cvt(hist[head[s]].d)));
        head[s]++;
      end else begin
        chk($sformatf("resp_valid[S=%0d]", depth(s)), 64'(rv_a[s]), 64'(m_rv));
      end
    end
    if (rst) begin
      hist.delete();
      head  = '{0, 0, 0};
      mconv = '0;
`ifdef U32_FP_ARB_RR_EN
      mptr  = NUM_REQ - 1;
`endif
    end else if (ce) begin
      if (gid >= 0) begin
        ent.id  = gid;
        ent.d   = req_data[32*gid +: 32];
        ent.acc = ecnt;
        hist.push_back(ent);
        mconv   = ent.d;
`ifdef U32_FP_ARB_RR_EN
        mptr    = gid;
`endif
      end
      ecnt++;
    end
  end

  logic [NUM_REQ-1:0] acc;
  logic [NUM_REQ-1:0] snap_rdy;
  logic [NUM_REQ-1:0] snap_rv   [3];
  logic [33:0]        snap_rd   [3];
  logic [31:0]        snap_ci   [3];
  logic               snap_busy [3];

  function automatic logic [31:0] rnd();
    case ($urandom_range(3))
      0:       return 32'(  $urandom_range(15));
      1:       return 32'hFFFF_FF00 | 32'($urandom_range(255));
      default: return $urandom;
    endcase
  endfunction

  task automatic step(input logic [NUM_REQ-1:0] keep, input int pct);
    @(negedge clk);
    acc      = req_valid & rdy_a[0];
    snap_rdy = rdy_a[0];
    for (int s = 0; s < 3; s++) begin
      snap_rv[s]   = rv_a[s];
      snap_rd[s]   = rd_a[s];
      snap_ci[s]   = ci_a[s];
      snap_busy[s] = busy_a[s];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (acc[k]) vld[k] = 1'b0;
      if (!vld[k] && (keep[k] || int'($urandom_range(99)) < pct)) begin
        vld[k] = 1'b1;
        dat[k] = rnd();
      end
    end
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step('0, 0);
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    vld = '0;
    for (int i = 0; i < n; i++) step('0, 0);
  endtask

  logic [NUM_REQ-1:0] exp_g;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    chk("cvt_zero", 64'(cvt(32'd0)), 64'h0);
    chk("cvt_one", 64'(cvt(32'd1)), 64'h1_3F80_0000);
    chk("cvt_three", 64'(cvt(32'd3)), 64'h1_4040_0000);
    chk("cvt_tie_even", 64'(cvt(32'h0100_0001)), 64'h1_4B80_0000);
    chk("cvt_max", 64'(cvt(32'hFFFF_FFFF)), 64'h1_4F80_0000);

    rst = 1'b1;
    ce  = 1'b1;
    vld = '0;
    for (int k = 0; k < NUM_REQ; k++) dat[k] = '0;
    step('0, 0);
    step('0, 0);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("reset_conv_I", 64'(snap_ci[s]), 64'h0);
      chk("reset_busy", 64'(snap_busy[s]), 64'h0);
      chk("reset_resp_valid", 64'(snap_rv[s]), 64'h0);
    end
    chk("reset_ready", 64'(snap_rdy), 64'h0);

    // Single request from requester 2 carrying 1.
    vld[2] = 1'b1;
    dat[2] = 32'd1;
    step('0, 0);
    chk("single_grant", 64'(snap_rdy), 64'h4);
    for (int k = 1; k <= 6; k++) begin
      step('0, 0);
      for (int s = 0; s < 3; s++) begin
        if (k == 1) chk("single_conv_I", 64'(snap_ci[s]), 64'h1);
        chk($sformatf("single_resp_valid[S=%0d,k=%0d]", depth(s), k), 64'(snap_rv[s]),
            (k == 1 + depth(s)) ? 64'h4 : 64'h0);
        if (k == 1 + depth(s)) chk("single_resp_data", 64'(snap_rd[s]), 64'h1_3F80_0000);
      end
    end

    // All requesters held valid.
    do_rst();
    vld = '1;
    for (int k = 0; k < NUM_REQ; k++) dat[k] = rnd();
    for (int i = 0; i < 12; i++) begin
      step('1, 0);
`ifdef U32_FP_ARB_RR_EN
      exp_g = NUM_REQ'(1 << (i % NUM_REQ));
`else
      exp_g = NUM_REQ'(1);
`endif
      chk($sformatf("all_valid_grant[%0d]", i), 64'(acc), 64'(exp_g));
    end
    drain(8);

    // Requesters 1 and 3 held valid.
    do_rst();
    vld = 4'b1010;
    dat[1] = rnd();
    dat[3] = rnd();
    for (int i = 0; i < 8; i++) begin
      step(4'b1010, 0);
`ifdef U32_FP_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
`else
      exp_g = 4'b0010;
`endif
      chk($sformatf("pair_grant[%0d]", i), 64'(acc), 64'(exp_g));
    end
    drain(8);

    // Clock-enable stall with three operands in flight.
    do_rst();
    vld = 4'b0111;
    for (int k = 0; k < 3; k++) dat[k] = rnd();
    for (int i = 0; i < 3; i++) begin
      step('0, 0);
      chk($sformatf("stall_accept[%0d]", i), 64'(acc), 64'(1 << i));
    end
    vld[3] = 1'b1;
    dat[3] = rnd();
    ce     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step('0, 0);
      chk("stall_ready", 64'(snap_rdy), 64'h0);
      chk("stall_resp_valid", 64'(snap_rv[2]), 64'h0);
    end
    ce = 1'b1;
    drain(10);

    // Reset with two operands in flight and ce low.
    do_rst();
    vld = 4'b0011;
    dat[0] = rnd();
    dat[1] = rnd();
    step('0, 0);
    step('0, 0);
    ce  = 1'b0;
    rst = 1'b1;
    step('0, 0);
    rst = 1'b0;
    ce  = 1'b1;
    vld = 4'b0110;
    dat[1] = rnd();
    dat[2] = rnd();
    step('0, 0);
    for (int s = 0; s < 3; s++) begin
      chk("midrst_conv_I", 64'(snap_ci[s]), 64'h0);
      chk("midrst_busy", 64'(snap_busy[s]), 64'h0);
      chk("midrst_resp_valid", 64'(snap_rv[s]), 64'h0);
    end
    chk("midrst_first_grant", 64'(snap_rdy), 64'h2);
    drain(10);

    // Random traffic with random stalls and occasional resets.
    for (int i = 0; i < 400; i++) begin
      ce  = ($urandom_range(4) != 0);
      rst = ($urandom_range(99) == 0);
      step('0, 40);
    end
    rst = 1'b0;
    ce  = 1'b1;
    drain(12);
    for (int s = 0; s < 3; s++) chk("final_busy", 64'(snap_busy[s]), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
